// File: rtl/sw_pe_gen.sv
// sw_pe_gen: affine-gap Smith-Waterman / Needleman-Wunsch processing element on biased unsigned scores.
// Define SW_PE_POS_TRACK_EN to build the target-position counter that drives HighPos_out.
module sw_pe_gen #(
    parameter int SCORE_WIDTH = 12,
    parameter int SYM_WIDTH   = 2,
    parameter int POS_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_in,
    input  logic                   global_mode,
    input  logic [SYM_WIDTH-1:0]   data_in,
    input  logic [SYM_WIDTH-1:0]   query,
    input  logic [SCORE_WIDTH-1:0] M_in,
    input  logic [SCORE_WIDTH-1:0] I_in,
    input  logic [SCORE_WIDTH-1:0] High_in,
    input  logic [POS_WIDTH-1:0]   HighPos_in,
    input  logic [SCORE_WIDTH-1:0] match,
    input  logic [SCORE_WIDTH-1:0] mismatch,
    input  logic [SCORE_WIDTH-1:0] gap_open,
    input  logic [SCORE_WIDTH-1:0] gap_extend,
    output logic [SYM_WIDTH-1:0]   data_out,
    output logic [SCORE_WIDTH-1:0] M_out,
    output logic [SCORE_WIDTH-1:0] I_out,
    output logic [SCORE_WIDTH-1:0] High_out,
    output logic [POS_WIDTH-1:0]   HighPos_out,
    output logic                   en_out,
    output logic                   vld
);
    localparam int XW = SCORE_WIDTH + 2;
    localparam logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state;
    logic [SCORE_WIDTH-1:0] m_diag, i_diag;
    logic                   mode_q;

    function automatic logic [SCORE_WIDTH-1:0] umax(input logic [SCORE_WIDTH-1:0] a, b);
        return (a > b) ? a : b;
    endfunction

    // Biased score plus signed penalty, widened so nothing wraps, then clamped to the score range.
    function automatic logic [SCORE_WIDTH-1:0] add_sat(input logic [SCORE_WIDTH-1:0] s, p);
        logic signed [XW-1:0] sum;
        sum = $signed({2'b00, s}) + $signed({{2{p[SCORE_WIDTH-1]}}, p});
        if (sum[XW-1])
            return '0;
        else if (|sum[XW-2:SCORE_WIDTH])
            return '1;
        else
            return sum[SCORE_WIDTH-1:0];
    endfunction

    logic                   first, gmode;
    logic [SCORE_WIDTH-1:0] m_dg, i_dg, m_prev, i_prev, lut, m_sat, m_new, i_new, own, high_new;

    // Any cell not computed in CALC starts a fresh stream from an all-ZERO history.
    assign first    = (state != CALC);
    assign gmode    = first ? global_mode : mode_q;
    assign m_dg     = first ? ZERO : m_diag;
    assign i_dg     = first ? ZERO : i_diag;
    assign m_prev   = first ? ZERO : M_out;
    assign i_prev   = first ? ZERO : I_out;
    assign lut      = (data_in == query) ? match : mismatch;
    assign m_sat    = add_sat(umax(m_dg, i_dg), lut);
    assign m_new    = (!gmode && m_sat < ZERO) ? ZERO : m_sat;
    assign i_new    = umax(add_sat(umax(M_in, m_prev), gap_open), add_sat(umax(I_in, i_prev), gap_extend));
    assign own      = umax(m_new, i_new);
    assign high_new = (own > High_in) ? own : High_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            en_out   <= 1'b0;
            vld      <= 1'b0;
            data_out <= '0;
            M_out    <= ZERO;
            I_out    <= ZERO;
            High_out <= ZERO;
            m_diag   <= ZERO;
            i_diag   <= ZERO;
        end else begin
            vld <= 1'b0;
            if (en_in) begin
                state    <= CALC;
                en_out   <= 1'b1;
                data_out <= data_in;
                M_out    <= m_new;
                I_out    <= i_new;
                High_out <= high_new;
                m_diag   <= M_in;
                i_diag   <= I_in;
                if (first)
                    mode_q <= global_mode;
            end else if (state == CALC) begin
                state  <= DONE;
                en_out <= 1'b0;
                vld    <= 1'b1;
            end else begin
                state    <= IDLE;
                en_out   <= 1'b0;
                data_out <= '0;
                M_out    <= ZERO;
                I_out    <= ZERO;
                High_out <= ZERO;
                m_diag   <= ZERO;
                i_diag   <= ZERO;
            end
        end
    end

`ifdef SW_PE_POS_TRACK_EN
    logic [POS_WIDTH-1:0] pos, cur_pos, high_pos;

    assign cur_pos = first ? '0 : ((&pos) ? pos : pos + 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= '0;
            high_pos <= '0;
        end else if (en_in) begin
            pos      <= cur_pos;
            high_pos <= (own > High_in) ? cur_pos : HighPos_in;
        end else if (state != CALC) begin
            pos      <= '0;
            high_pos <= '0;
        end
    end

    assign HighPos_out = high_pos;
`else
    logic unused_high_pos;
    assign unused_high_pos = ^HighPos_in;
    assign HighPos_out     = '0;
`endif

endmodule

// File: tb/tb_sw_pe_gen.sv
// tb_sw_pe_gen: directed spec scenarios plus randomized streams against an integer reference model.
// Position expectations follow SW_PE_POS_TRACK_EN the same way the design does.
module tb_sw_pe_gen;
    localparam int ZERO   = 2048;
    localparam int MAXS   = 4095;
    localparam int MAXPOS = 65535;

    logic        clk = 1'b0;
    logic        rst, en_in, global_mode;
    logic [1:0]  data_in, query, data_out;
    logic [11:0] M_in, I_in, High_in, match, mismatch, gap_open, gap_extend;
    logic [11:0] M_out, I_out, High_out;
    logic [15:0] HighPos_in, HighPos_out;
    logic        en_out, vld;

    int n_chk = 0, n_pass = 0;

    // reference model: expected outputs and stream history
    int e_m, e_i, e_h, e_hp, e_d, e_en, e_vld, dg_m, dg_i, pos;
    bit streaming, gm;

    always #5 clk = ~clk;

    sw_pe_gen dut (
        .clk(clk), .rst(rst), .en_in(en_in), .global_mode(global_mode),
        .data_in(data_in), .query(query), .M_in(M_in), .I_in(I_in),
        .High_in(High_in), .HighPos_in(HighPos_in), .match(match),
        .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
        .data_out(data_out), .M_out(M_out), .I_out(I_out), .High_out(High_out),
        .HighPos_out(HighPos_out), .en_out(en_out), .vld(vld)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > MAXS) return MAXS;
        return v;
    endfunction

    function automatic int sgn(input logic [11:0] p);
        return int'($signed(p));
    endfunction

    task automatic model_reset();
        e_m = ZERO; e_i = ZERO; e_h = ZERO; e_hp = 0; e_d = 0; e_en = 0; e_vld = 0;
        dg_m = ZERO; dg_i = ZERO; pos = 0; streaming = 0; gm = 0;
    endtask

    task automatic model_edge();
        int pm, pi, dm, di, m, mi, own, hin;
        if (en_in) begin
            if (!streaming) begin
                gm = global_mode; pos = 0; pm = ZERO; pi = ZERO; dm = ZERO; di = ZERO;
            end else begin
                pm = e_m; pi = e_i; dm = dg_m; di = dg_i;
                if (pos < MAXPOS) pos++;
            end
            m = clamp(imax(dm, di) + ((data_in == query) ? sgn(match) : sgn(mismatch)));
            if (!gm && m < ZERO) m = ZERO;
            mi = imax(clamp(imax(int'(M_in), pm) + sgn(gap_open)),
                      clamp(imax(int'(I_in), pi) + sgn(gap_extend)));
            own = imax(m, mi);
            hin = int'(High_in);
`ifdef SW_PE_POS_TRACK_EN
            e_hp = (own > hin) ? pos : int'(HighPos_in);
`else
            e_hp = 0;
`endif
            e_h = (own > hin) ? own : hin;
            e_m = m; e_i = mi; e_d = int'(data_in); e_en = 1; e_vld = 0;
            dg_m = int'(M_in); dg_i = int'(I_in); streaming = 1;
        end else if (streaming) begin
            streaming = 0; e_en = 0; e_vld = 1;
        end else begin
            e_m = ZERO; e_i = ZERO; e_h = ZERO; e_hp = 0; e_d = 0; e_en = 0; e_vld = 0;
            dg_m = ZERO; dg_i = ZERO;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".M"}, M_out, e_m);
        chk({tag, ".I"}, I_out, e_i);
        chk({tag, ".High"}, High_out, e_h);
        chk({tag, ".HighPos"}, HighPos_out, e_hp);
        chk({tag, ".data"}, data_out, e_d);
        chk({tag, ".en"}, en_out, e_en);
        chk({tag, ".vld"}, vld, e_vld);
    endtask

    task automatic step(input string tag, input bit en, input logic [1:0] d);
        en_in = en; data_in = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // rst pulse placed between edges so the check sees it act without a clock
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    task automatic base_inputs();
        M_in = 12'd2048; I_in = 12'd2048; High_in = 12'd2048; HighPos_in = '0;
        match = 12'd2; mismatch = 12'd4095; gap_open = 12'd4093; gap_extend = 12'd4095;
        query = 2'd0; global_mode = 1'b0;
    endtask

    int exp_pos;
    int held_m;

    initial begin
        rst = 1'b1; en_in = 1'b0; data_in = '0;
        base_inputs();
        #2;
        model_reset();
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // match run, local mode
        step("match0", 1, 2'd0); chk("match0.M2050", M_out, 2050);
        step("match1", 1, 2'd0); chk("match1.M2050", M_out, 2050); chk("match1.H2050", High_out, 2050);
        step("match_end", 0, 2'd0);
        step("match_idle", 0, 2'd0);

        // floor in local mode, none in global mode
        step("floor_loc", 1, 2'd2); chk("floor_loc.M", M_out, 2048);
        step("floor_end", 0, 2'd0);
        global_mode = 1'b1;
        step("floor_glb", 1, 2'd2); chk("floor_glb.M", M_out, 2047);
        step("floor_end2", 0, 2'd0);
        step("floor_idle", 0, 2'd0);
        global_mode = 1'b0;

        // saturation at the top of the score range
        M_in = 12'd4094;
        step("sat0", 1, 2'd0);
        M_in = 12'd2048;
        step("sat1", 1, 2'd0); chk("sat1.M4095", M_out, 4095);
        step("sat_end", 0, 2'd0);
        step("sat_idle", 0, 2'd0);

        // termination after three cells
        step("term0", 1, 2'd0);
        step("term1", 1, 2'd1);
        step("term2", 1, 2'd0);
        held_m = e_m;
        step("term3", 0, 2'd0);
        chk("term3.vld", vld, 1); chk("term3.en", en_out, 0); chk("term3.hold", M_out, held_m);
        step("term4", 0, 2'd0);
        chk("term4.vld", vld, 0); chk("term4.M", M_out, ZERO); chk("term4.H", High_out, ZERO);

        // position: own max first exceeds High_in at target index 2
        High_in = 12'd2049; HighPos_in = 16'd7;
        step("pos0", 1, 2'd3);
        step("pos1", 1, 2'd3);
        step("pos2", 1, 2'd0);
`ifdef SW_PE_POS_TRACK_EN
        exp_pos = 2;
`else
        exp_pos = 0;
`endif
        chk("pos2.HighPos", HighPos_out, exp_pos);
        step("pos_end", 0, 2'd0);
        // tie with High_in keeps the incoming position
        High_in = 12'd2050;
        step("tie0", 1, 2'd3);
        step("tie1", 1, 2'd3);
        step("tie2", 1, 2'd0);
`ifdef SW_PE_POS_TRACK_EN
        exp_pos = 7;
`else
        exp_pos = 0;
`endif
        chk("tie2.HighPos", HighPos_out, exp_pos);
        chk("tie2.High", High_out, 2050);

        // asynchronous reset in the middle of a stream
        base_inputs();
        step("ar0", 1, 2'd0);
        step("ar1", 1, 2'd0);
        do_reset("async_rst");
        chk("async_rst.M", M_out, 2048); chk("async_rst.en", en_out, 0); chk("async_rst.vld", vld, 0);
        step("ar_first", 1, 2'd0); chk("ar_first.M", M_out, 2050);
        step("ar_end", 0, 2'd0);

        // randomized streams
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 99) < 2) do_reset("rnd_rst");
            M_in = 12'($urandom_range(0, 4095));
            I_in = 12'($urandom_range(0, 4095));
            High_in = 12'($urandom_range(0, 4095));
            HighPos_in = 16'($urandom);
            global_mode = 1'($urandom_range(0, 1));
            query = 2'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                match = 12'($urandom_range(0, 6));
                mismatch = 12'(-int'($urandom_range(0, 6)));
                gap_open = 12'(-int'($urandom_range(0, 8)));
                gap_extend = 12'(-int'($urandom_range(0, 4)));
            end
            step("rnd", $urandom_range(0, 3) != 0, 2'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
